// File: rtl/ifetch_ir_pkg.sv
// Shared definitions for the instruction-fetch / instruction-register stage:
// state encoding, IR field positions, opcodes and the PC step.
package ifetch_ir_pkg;

    typedef logic [1:0] fetch_state_t;

    localparam fetch_state_t ST_IDLE = 2'd0;
    localparam fetch_state_t ST_REQ  = 2'd1;
    localparam fetch_state_t ST_DONE = 2'd2;

    localparam int OP_HI    = 31;
    localparam int OP_LO    = 26;
    localparam int RS_HI    = 25;
    localparam int RS_LO    = 21;
    localparam int RT_HI    = 20;
    localparam int RT_LO    = 16;
    localparam int RD_HI    = 15;
    localparam int RD_LO    = 11;
    localparam int SHAMT_HI = 10;
    localparam int SHAMT_LO = 6;
    localparam int FUNCT_HI = 5;
    localparam int FUNCT_LO = 0;
    localparam int IMM_HI   = 15;
    localparam int IMM_LO   = 0;
    localparam int JADDR_HI = 25;
    localparam int JADDR_LO = 0;

    // Opcodes consumed by the main control FSM
    localparam logic [5:0] OPC_RTYPE = 6'h00;
    localparam logic [5:0] OPC_J     = 6'h02;
    localparam logic [5:0] OPC_BEQ   = 6'h04;
    localparam logic [5:0] OPC_ADDI  = 6'h08;
    localparam logic [5:0] OPC_LW    = 6'h23;
    localparam logic [5:0] OPC_SW    = 6'h2B;

    localparam logic [31:0] PC_INCR = 32'd4;

endpackage

// File: rtl/ifetch_ir_if.sv
// Instruction-memory read port: req/ack handshake with word address and data.
interface ifetch_ir_if;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (output mem_req, output mem_addr, input mem_ack, input mem_rdata);
    modport slave  (input mem_req, input mem_addr, output mem_ack, output mem_rdata);
endinterface

// File: rtl/ifetch_ir_decode.sv
// Purely combinational slicing of the instruction register into MIPS fields.
module ifetch_ir_decode
    import ifetch_ir_pkg::*;
(
    input  logic [31:0] ir,
    output logic [5:0]  op,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [4:0]  shamt,
    output logic [5:0]  funct,
    output logic [15:0] imm16,
    output logic [25:0] jaddr
);

    assign op    = ir[OP_HI:OP_LO];
    assign rs    = ir[RS_HI:RS_LO];
    assign rt    = ir[RT_HI:RT_LO];
    assign rd    = ir[RD_HI:RD_LO];
    assign shamt = ir[SHAMT_HI:SHAMT_LO];
    assign funct = ir[FUNCT_HI:FUNCT_LO];
    assign imm16 = ir[IMM_HI:IMM_LO];
    assign jaddr = ir[JADDR_HI:JADDR_LO];

endmodule

// File: rtl/ifetch_ir.sv
// Fetch stage of the multi-cycle MIPS datapath: owns the PC, the IR, the
// memory read handshake and a watchdog that aborts a fetch with no response.
module ifetch_ir
    import ifetch_ir_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          TIMEOUT  = 255,
    parameter int          TW       = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               fetch_start,
    input  logic               pc_we,
    input  logic [31:0]        pc_in,
    ifetch_ir_if.master        bus,
    output logic               busy,
    output logic               ir_valid,
    output logic               fetch_err,
    output logic [31:0]        pc,
    output logic [31:0]        ir,
    output logic [5:0]         op,
    output logic [4:0]         rs,
    output logic [4:0]         rt,
    output logic [4:0]         rd,
    output logic [4:0]         shamt,
    output logic [5:0]         funct,
    output logic [15:0]        imm16,
    output logic [25:0]        jaddr
);

    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] CNT_ONE  = TW'(1);
    localparam logic [TW-1:0] CNT_ZERO = TW'(0);

    fetch_state_t  state_r, state_s;
    logic [31:0]   pc_r, pc_s;
    logic [31:0]   ir_r, ir_s;
    logic [TW-1:0] cnt_r, cnt_s;
    logic          err_r, err_s;
    logic          req_r, req_s;
    logic          busy_r;
    logic          valid_r, valid_s;

    // Next-state, PC/IR update and watchdog decisions
    always_comb begin
        state_s = state_r;
        pc_s    = pc_r;
        ir_s    = ir_r;
        cnt_s   = cnt_r;
        err_s   = err_r;
        req_s   = 1'b0;
        valid_s = 1'b0;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                // A same-cycle pc_we and fetch_start fetch from the new PC,
                // which falls out naturally because mem_addr tracks pc_r.
                if (pc_we) begin
                    pc_s = pc_in;
                end else begin
                    pc_s = pc_r;
                end
                if (fetch_start) begin
                    state_s = ST_REQ;
                    req_s   = 1'b1;
                    cnt_s   = CNT_ZERO;
                    err_s   = 1'b0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (bus.mem_ack) begin
                    ir_s    = bus.mem_rdata;
                    pc_s    = pc_r + PC_INCR;
                    state_s = ST_DONE;
                    valid_s = 1'b1;
                end else if (cnt_r == TO_LAST) begin
                    err_s   = 1'b1;
                    state_s = ST_IDLE;
                end else begin
                    cnt_s   = cnt_r + CNT_ONE;
                    req_s   = 1'b1;
                    state_s = ST_REQ;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset drops mem_req asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            pc_r    <= RESET_PC;
            ir_r    <= 32'h0000_0000;
            cnt_r   <= CNT_ZERO;
            err_r   <= 1'b0;
            req_r   <= 1'b0;
            busy_r  <= 1'b0;
            valid_r <= 1'b0;
        end else begin
            state_r <= state_s;
            pc_r    <= pc_s;
            ir_r    <= ir_s;
            cnt_r   <= cnt_s;
            err_r   <= err_s;
            req_r   <= req_s;
            busy_r  <= req_s;
            valid_r <= valid_s;
        end
    end

    assign bus.mem_req  = req_r;
    assign bus.mem_addr = pc_r;
    assign busy         = busy_r;
    assign ir_valid     = valid_r;
    assign fetch_err    = err_r;
    assign pc           = pc_r;
    assign ir           = ir_r;

    ifetch_ir_decode u_decode (
        .ir    (ir_r),
        .op    (op),
        .rs    (rs),
        .rt    (rt),
        .rd    (rd),
        .shamt (shamt),
        .funct (funct),
        .imm16 (imm16),
        .jaddr (jaddr)
    );

endmodule

// File: tb/tb_ifetch_ir.sv
// Directed bench for ifetch_ir: per-cycle vector table plus hand-written
// reset-mid-fetch and minimum-latency sequences.
module tb_ifetch_ir;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fetch_start = 1'b0;
    logic        pc_we = 1'b0;
    logic [31:0] pc_in = 32'h0;
    logic        busy, ir_valid, fetch_err;
    logic [31:0] pc, ir;
    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd, shamt;
    logic [15:0] imm16;
    logic [25:0] jaddr;

    int errors = 0;
    int checks = 0;

    ifetch_ir_if bus ();

    ifetch_ir #(.RESET_PC(32'h0000_0000), .TIMEOUT(4), .TW(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .fetch_start (fetch_start),
        .pc_we       (pc_we),
        .pc_in       (pc_in),
        .bus         (bus),
        .busy        (busy),
        .ir_valid    (ir_valid),
        .fetch_err   (fetch_err),
        .pc          (pc),
        .ir          (ir),
        .op          (op),
        .rs          (rs),
        .rt          (rt),
        .rd          (rd),
        .shamt       (shamt),
        .funct       (funct),
        .imm16       (imm16),
        .jaddr       (jaddr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        fs;
        logic        we;
        logic [31:0] pcin;
        logic        ack;
        logic [31:0] rdata;
        logic        req;
        logic [31:0] pc;
        logic [31:0] ir;
        logic        valid;
        logic        err;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic fs, input logic we, input logic [31:0] pcin,
                       input logic ack, input logic [31:0] rdata,
                       input logic req, input logic [31:0] epc, input logic [31:0] eir,
                       input logic valid, input logic err);
        vec_t v;
        v.fs = fs; v.we = we; v.pcin = pcin; v.ack = ack; v.rdata = rdata;
        v.req = req; v.pc = epc; v.ir = eir; v.valid = valid; v.err = err;
        vq.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        fetch_start = 1'b0;
        pc_we = 1'b0;
        pc_in = 32'h0;
        bus.mem_ack = 1'b0;
        bus.mem_rdata = 32'h0;
    endtask

    initial begin
        logic [31:0] eir;
        int pulses;
        int waited;

        drive_idle();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("reset_pc", pc, 32'h0);
        chk("reset_ir", ir, 32'h0);
        chk("reset_req", {31'h0, bus.mem_req}, 32'h0);
        chk("reset_busy", {31'h0, busy}, 32'h0);
        chk("reset_valid", {31'h0, ir_valid}, 32'h0);
        chk("reset_err", {31'h0, fetch_err}, 32'h0);

        // fetch at 0, ack two cycles after mem_req rises
        add(1, 0, 32'h0, 0, 32'h0,          1, 32'h0, 32'h0,         0, 0);
        add(0, 0, 32'h0, 0, 32'h0,          1, 32'h0, 32'h0,         0, 0);
        add(0, 0, 32'h0, 0, 32'h0,          1, 32'h0, 32'h0,         0, 0);
        add(0, 0, 32'h0, 1, 32'h2008_FFFF,  0, 32'h4, 32'h2008_FFFF, 1, 0);
        add(0, 0, 32'h0, 0, 32'h0,          0, 32'h4, 32'h2008_FFFF, 0, 0);
        // fetch_start / pc_we during REQ are ignored
        add(1, 0, 32'h0,   0, 32'h0,         1, 32'h4, 32'h2008_FFFF, 0, 0);
        add(1, 1, 32'h100, 0, 32'h0,         1, 32'h4, 32'h2008_FFFF, 0, 0);
        add(0, 0, 32'h0,   1, 32'h8C01_0004, 0, 32'h8, 32'h8C01_0004, 1, 0);
        // stray acks in DONE and IDLE
        add(0, 0, 32'h0, 1, 32'hDEAD_BEEF,  0, 32'h8, 32'h8C01_0004, 0, 0);
        add(0, 0, 32'h0, 1, 32'h1234_5678,  0, 32'h8, 32'h8C01_0004, 0, 0);
        // back-to-back fetch started in DONE
        add(1, 0, 32'h0, 0, 32'h0,          1, 32'h8,  32'h8C01_0004, 0, 0);
        add(0, 0, 32'h0, 1, 32'h0000_0020,  0, 32'hC,  32'h0000_0020, 1, 0);
        add(1, 0, 32'h0, 0, 32'h0,          1, 32'hC,  32'h0000_0020, 0, 0);
        add(0, 0, 32'h0, 1, 32'hAC22_0008,  0, 32'h10, 32'hAC22_0008, 1, 0);
        add(0, 0, 32'h0, 0, 32'h0,          0, 32'h10, 32'hAC22_0008, 0, 0);
        // timeout: mem_req high exactly 4 cycles, then sticky error
        add(1, 0, 32'h0, 0, 32'h0,          1, 32'h10, 32'hAC22_0008, 0, 0);
        add(0, 0, 32'h0, 0, 32'h0,          1, 32'h10, 32'hAC22_0008, 0, 0);
        add(0, 0, 32'h0, 0, 32'h0,          1, 32'h10, 32'hAC22_0008, 0, 0);
        add(0, 0, 32'h0, 0, 32'h0,          1, 32'h10, 32'hAC22_0008, 0, 0);
        add(0, 0, 32'h0, 0, 32'h0,          0, 32'h10, 32'hAC22_0008, 0, 1);
        add(0, 0, 32'h0, 0, 32'h0,          0, 32'h10, 32'hAC22_0008, 0, 1);
        add(1, 0, 32'h0, 0, 32'h0,          1, 32'h10, 32'hAC22_0008, 0, 0);
        add(0, 0, 32'h0, 1, 32'h0000_0000,  0, 32'h14, 32'h0000_0000, 1, 0);
        add(0, 0, 32'h0, 0, 32'h0,          0, 32'h14, 32'h0000_0000, 0, 0);
        // pc_we with fetch_start, then wrap of pc+4
        add(1, 1, 32'hFFFF_FFFC, 0, 32'h0,          1, 32'hFFFF_FFFC, 32'h0,         0, 0);
        add(0, 0, 32'h0,         1, 32'h3C01_ABCD,  0, 32'h0,         32'h3C01_ABCD, 1, 0);
        add(0, 1, 32'h200,       0, 32'h0,          0, 32'h200,       32'h3C01_ABCD, 0, 0);
        add(0, 1, 32'h300,       0, 32'h0,          0, 32'h300,       32'h3C01_ABCD, 0, 0);

        foreach (vq[i]) begin
            @(negedge clk);
            fetch_start   = vq[i].fs;
            pc_we         = vq[i].we;
            pc_in         = vq[i].pcin;
            bus.mem_ack   = vq[i].ack;
            bus.mem_rdata = vq[i].rdata;
            @(posedge clk);
            #1;
            eir = vq[i].ir;
            chk($sformatf("v%0d_req", i),   {31'h0, bus.mem_req}, {31'h0, vq[i].req});
            chk($sformatf("v%0d_busy", i),  {31'h0, busy},        {31'h0, vq[i].req});
            chk($sformatf("v%0d_pc", i),    pc,                   vq[i].pc);
            chk($sformatf("v%0d_addr", i),  bus.mem_addr,         vq[i].pc);
            chk($sformatf("v%0d_ir", i),    ir,                   vq[i].ir);
            chk($sformatf("v%0d_valid", i), {31'h0, ir_valid},    {31'h0, vq[i].valid});
            chk($sformatf("v%0d_err", i),   {31'h0, fetch_err},   {31'h0, vq[i].err});
            chk($sformatf("v%0d_op", i),    {26'h0, op},          {26'h0, eir[31:26]});
            chk($sformatf("v%0d_imm", i),   {16'h0, imm16},       {16'h0, eir[15:0]});
            chk($sformatf("v%0d_funct", i), {26'h0, funct},       {26'h0, eir[5:0]});
            if (i == 3) begin
                chk("addi_op",  {26'h0, op},    32'h08);
                chk("addi_rs",  {27'h0, rs},    32'h0);
                chk("addi_rt",  {27'h0, rt},    32'h8);
                chk("addi_imm", {16'h0, imm16}, 32'hFFFF);
            end
        end
        @(negedge clk);
        drive_idle();

        // minimum-latency fetch from 0x300: ack in the first REQ cycle
        fetch_start = 1'b1;
        @(negedge clk);
        fetch_start = 1'b0;
        waited = 0;
        while (bus.mem_req !== 1'b1 && waited < 8) begin
            @(negedge clk);
            waited++;
        end
        chk("min_req_wait", waited, 0);
        bus.mem_ack = 1'b1;
        bus.mem_rdata = 32'h0800_0040;
        @(posedge clk);
        #1;
        bus.mem_ack = 1'b0;
        pulses = 0;
        for (int c = 0; c < 4; c++) begin
            if (ir_valid === 1'b1) pulses++;
            @(posedge clk);
            #1;
        end
        chk("min_valid_pulses", pulses, 1);
        chk("min_pc", pc, 32'h304);
        chk("min_op", {26'h0, op}, 32'h02);
        chk("min_jaddr", {6'h0, jaddr}, 32'h40);
        chk("min_rd", {27'h0, rd}, 32'h0);
        chk("min_shamt", {27'h0, shamt}, 32'h1);

        // reset in the middle of a fetch, with an ack pending
        @(negedge clk);
        fetch_start = 1'b1;
        @(posedge clk);
        #1;
        fetch_start = 1'b0;
        chk("rst_pre_req", {31'h0, bus.mem_req}, 32'h1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_async_req", {31'h0, bus.mem_req}, 32'h0);
        chk("rst_async_busy", {31'h0, busy}, 32'h0);
        bus.mem_ack = 1'b1;
        bus.mem_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        bus.mem_ack = 1'b0;
        chk("rst_pc", pc, 32'h0);
        chk("rst_ir", ir, 32'h0);
        chk("rst_req", {31'h0, bus.mem_req}, 32'h0);
        chk("rst_valid", {31'h0, ir_valid}, 32'h0);
        chk("rst_err", {31'h0, fetch_err}, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ifetch_ir.md
Name: ifetch_ir

Overview:
- Instruction-fetch and instruction-register stage of the multi-cycle MIPS datapath.
- On a fetch request from the main control FSM, it issues a word read to instruction memory with a req/ack handshake, latches the returned word into the IR, and advances the PC by 4.
- It decodes the IR into fields. imm16 is the direct input of the sign-extension unit.
- Also owns the PC register and a response-timeout watchdog.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- TIMEOUT, 255, maximum cycles mem_req may wait for mem_ack before aborting (1..2^TW-1).
- TW, 8, width of the timeout counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- fetch_start  in  1  one-cycle request from control FSM to fetch at the current PC.
- pc_we  in  1  load pc_in into the PC (branch/jump writeback).
- pc_in  in  32  new PC value.
- mem_req  out  1  instruction-memory read request.
- mem_addr  out  32  word address; always equals pc.
- mem_ack  in  1  memory has returned data on mem_rdata this cycle.
- mem_rdata  in  32  instruction word.
- busy  out  1  high while in REQ.
- ir_valid  out  1  one-cycle pulse: IR updated.
- fetch_err  out  1  sticky timeout flag.
- pc  out  32  current PC.
- ir  out  32  instruction register.
- op  out  6  ir[31:26].
- rs  out  5  ir[25:21].
- rt  out  5  ir[20:16].
- rd  out  5  ir[15:11].
- shamt  out  5  ir[10:6].
- funct  out  6  ir[5:0].
- imm16  out  16  ir[15:0], to the sign-extend unit.
- jaddr  out  26  ir[25:0].

Behaviour:
- Reset (async, rst_n=0): state=IDLE, pc=RESET_PC, ir=0, mem_req=0, busy=0, ir_valid=0, fetch_err=0, timeout counter=0.
- States: IDLE, REQ, DONE.
- IDLE:
  - fetch_start=1 -> REQ; mem_req=1 from the next cycle; counter cleared; fetch_err cleared.
  - pc_we=1 -> pc<=pc_in.
  - pc_we and fetch_start in the same cycle: the PC loads pc_in and the fetch uses the new PC.
- REQ:
  - mem_req=1 and busy=1; mem_addr=pc held stable.
  - mem_ack=1 -> ir<=mem_rdata, pc<=pc+4 (mod 2^32; 32'hFFFF_FFFC wraps to 0), mem_req drops the next cycle -> DONE.
  - No ack: counter increments. When counter==TIMEOUT-1 without ack -> fetch_err<=1, mem_req drops, ir and pc unchanged -> IDLE.
  - fetch_start and pc_we are ignored in REQ; the PC is never changed mid-fetch.
- DONE: ir_valid=1 for exactly this cycle -> IDLE.
  - pc_we is honoured in DONE (same rule as IDLE).
  - fetch_start in DONE is accepted and goes directly to REQ, giving back-to-back fetches.
- Latency: fetch_start sampled at edge 0; mem_req high at cycle 1. With ack in cycle k, ir_valid is high in cycle k+1. Minimum fetch is 3 cycles (ack in the first REQ cycle).
- mem_ack outside REQ is ignored.
- Field outputs are combinational slices of ir and are stable except on the IR-load edge.
- fetch_err holds until the next accepted fetch_start or reset.
- Reset mid-fetch: mem_req drops immediately (asynchronous); a pending ack is discarded.

Decomposition:
- Shared package (mips_pkg):
  - State encoding enum (IDLE/REQ/DONE).
  - Field bit-position constants (OP_HI/LO, RS, RT, RD, SHAMT, FUNCT, IMM, JADDR).
  - Opcode constants used by control.
  - PC_INCR=4.
- One natural sub-module, ir_field_decode: purely combinational IR slicing. The FSM, PC and timeout counter live in ifetch_ir.

Test Plan:
- Reset with rst_n low mid-REQ -> mem_req=0 immediately; after release pc=0, ir=0, all flags 0.
- fetch_start at pc=0; ack 2 cycles after mem_req with rdata=32'h2008_FFFF -> ir=32'h2008FFFF, op=6'h08, rs=0, rt=8, imm16=16'hFFFF; pc=4; ir_valid single pulse.
- pc_we=1 with pc_in=32'hFFFF_FFFC and fetch_start in the same cycle -> mem_addr=32'hFFFFFFFC; after ack pc=0 (wrap).
- TIMEOUT=4 with no ack -> mem_req high exactly 4 cycles; fetch_err=1; pc and ir unchanged. Next fetch_start clears fetch_err.
- fetch_start and pc_we=1 (pc_in=32'h100) asserted during REQ -> both ignored; pc=old pc+4 after ack.
- Back-to-back: fetch_start in DONE -> second mem_req follows with no IDLE gap at pc+4. A stray mem_ack in IDLE -> no IR change.
